obi_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave OBI arbiter for the core testbench memory path. It sits between the requesters (core data port, debug system-bus master, coprocessor memory port) and the single data port of the RAM model, replacing the previous fixed two-way muxing. It uses round-robin arbitration and holds each stalled request stable, as OBI requires. An in-order ID FIFO routes each response back to the master that issued the request.

---
 rtl/obi_rr_arbiter_if.sv | 42 ++++
 rtl/obi_rr_arbiter.sv | 102 ++++++++++
 tb/tb_obi_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle between the requesting masters, the OBI arbiter and the single slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface obi_rr_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
);
   localparam int BW = DATA_WIDTH / 8;

   logic [NUM_MASTERS-1:0]            m_req_i;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
   logic [NUM_MASTERS-1:0]            m_we_i;
   logic [NUM_MASTERS*BW-1:0]         m_be_i;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
   logic [NUM_MASTERS-1:0]            m_gnt_o;
   logic [NUM_MASTERS-1:0]            m_rvalid_o;
   logic [DATA_WIDTH-1:0]             m_rdata_o;

   logic                              s_req_o;
   logic [ADDR_WIDTH-1:0]             s_addr_o;
   logic                              s_we_o;
   logic [BW-1:0]                     s_be_o;
   logic [DATA_WIDTH-1:0]             s_wdata_o;
   logic                              s_gnt_i;
   logic                              s_rvalid_i;
   logic [DATA_WIDTH-1:0]             s_rdata_i;
   logic                              rsp_err_o;

   modport slave (
      input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
      input  s_gnt_i, s_rvalid_i, s_rdata_i,
      output m_gnt_o, m_rvalid_o, m_rdata_o,
      output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o, rsp_err_o
   );

   modport master (
      output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
      output s_gnt_i, s_rvalid_i, s_rdata_i,
      input  m_gnt_o, m_rvalid_o, m_rdata_o,
      input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o, rsp_err_o
   );
endinterface

// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI round-robin arbiter with stall lock and an in-order ID FIFO that routes
// responses back to the issuing master.
module obi_rr_arbiter #(
   parameter int NUM_MASTERS     = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input logic              clk_i,
   input logic              rst_ni,
   obi_rr_arbiter_if.slave  bus
);
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [IW-1:0] rr_ptr_q, lock_idx_q, rr_sel, sel, head;
   logic          lock_q, lock_hit, any_req, fifo_full, fifo_empty;
   logic          push, pop, stall;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [IW-1:0] fifo_q [MAX_OUTSTANDING];

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
      return (int'(idx) >= NUM_MASTERS - 1) ? '0 : idx + IW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (int'(p) >= MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
   endfunction

   // Descending scan so the lowest rotation offset from rr_ptr_q wins.
   always_comb begin
      int idx;
      idx    = 0;
      rr_sel = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
         if (bus.m_req_i[idx]) rr_sel = IW'(idx);
      end
   end

   assign any_req    = |bus.m_req_i;
   assign lock_hit   = lock_q && bus.m_req_i[lock_idx_q];
   assign sel        = lock_hit ? lock_idx_q : rr_sel;
   assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (cnt_q == '0);
   assign head       = fifo_q[rd_ptr_q];

   assign push  = bus.s_req_o && bus.s_gnt_i;
   assign stall = bus.s_req_o && !bus.s_gnt_i;
   assign pop   = bus.s_rvalid_i && !fifo_empty;

   assign bus.s_req_o   = any_req && !fifo_full;
   assign bus.s_addr_o  = bus.m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.s_we_o    = bus.m_we_i[sel];
   assign bus.s_be_o    = bus.m_be_i[int'(sel)*BW +: BW];
   assign bus.s_wdata_o = bus.m_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign bus.m_rdata_o = bus.s_rdata_i;
   assign bus.rsp_err_o = bus.s_rvalid_i && fifo_empty;

   always_comb begin
      bus.m_gnt_o    = '0;
      bus.m_rvalid_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         bus.m_gnt_o[i]    = push && (int'(sel) == i);
         bus.m_rvalid_o[i] = pop && (int'(head) == i);
      end
   end

   // Arbitration and FIFO bookkeeping; a dropped locked request simply releases the lock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         if (push) begin
            rr_ptr_q <= rr_next(sel);
            lock_q   <= 1'b0;
            wr_ptr_q <= ptr_next(wr_ptr_q);
         end else if (stall) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end else if (!lock_hit) begin
            lock_q <= 1'b0;
         end
         if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Master-index storage carries no reset; only the pointers and count qualify it.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= sel;
   end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomized and directed bench for obi_rr_arbiter against a queue-based reference model.
module tb_obi_rr_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   obi_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   obi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO))
      dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   obi_rr_arbiter_if #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
   obi_rr_arbiter #(.NUM_MASTERS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO))
      dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int rr_m = 0;
   int lock_m = -1;
   int q[$];
   int gnt_log[$];

   logic          last_sreq, last_err;
   logic [N-1:0]  last_gnt, last_rv;
   logic [AW-1:0] last_addr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rr_m = 0;
      lock_m = -1;
      q.delete();
   endtask

   task automatic idle_inputs();
      bus.m_req_i = '0; bus.m_addr_i = '0; bus.m_we_i = '0; bus.m_be_i = '0; bus.m_wdata_i = '0;
      bus.s_gnt_i = 1'b0; bus.s_rvalid_i = 1'b0;
   endtask

   task automatic set_m(input int i, input bit req, input logic [AW-1:0] addr, input bit we,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
      bus.m_req_i[i] = req;
      bus.m_addr_i[i*AW +: AW] = addr;
      bus.m_we_i[i] = we;
      bus.m_be_i[i*BW +: BW] = be;
      bus.m_wdata_i[i*DW +: DW] = wd;
   endtask

   // One clock: compare DUT outputs with the model at negedge, then advance the model.
   task automatic step();
      int sel;
      bit lh, e_sreq, e_push, e_pop, e_err;
      logic [N-1:0] e_gnt, e_rv;
      @(negedge clk);
      lh  = (lock_m >= 0) && bus.m_req_i[lock_m];
      sel = 0;
      if (lh) sel = lock_m;
      else begin
         for (int k = 0; k < N; k++) begin
            if (bus.m_req_i[(rr_m + k) % N]) begin
               sel = (rr_m + k) % N;
               break;
            end
         end
      end
      e_sreq = (bus.m_req_i != '0) && (q.size() < MO);
      e_push = e_sreq && bus.s_gnt_i;
      e_pop  = bus.s_rvalid_i && (q.size() > 0);
      e_err  = bus.s_rvalid_i && (q.size() == 0);
      e_gnt = '0;
      if (e_push) e_gnt[sel] = 1'b1;
      e_rv = '0;
      if (e_pop) e_rv[q[0]] = 1'b1;

      check("s_req", bus.s_req_o, e_sreq);
      check("m_gnt", bus.m_gnt_o, e_gnt);
      check("m_rvalid", bus.m_rvalid_o, e_rv);
      check("rsp_err", bus.rsp_err_o, e_err);
      check("m_rdata", bus.m_rdata_o, bus.s_rdata_i);
      if (e_sreq) begin
         check("s_addr", bus.s_addr_o, bus.m_addr_i[sel*AW +: AW]);
         check("s_we", bus.s_we_o, bus.m_we_i[sel]);
         check("s_be", bus.s_be_o, bus.m_be_i[sel*BW +: BW]);
         check("s_wdata", bus.s_wdata_o, bus.m_wdata_i[sel*DW +: DW]);
      end
      last_sreq = bus.s_req_o; last_gnt = bus.m_gnt_o; last_rv = bus.m_rvalid_o;
      last_err = bus.rsp_err_o; last_addr = bus.s_addr_o;
      for (int j = 0; j < N; j++) if (bus.m_gnt_o[j]) gnt_log.push_back(j);

      @(posedge clk);
      if (e_pop) void'(q.pop_front());
      if (e_push) begin
         q.push_back(sel);
         rr_m = (sel + 1) % N;
         lock_m = -1;
      end else if (e_sreq) begin
         lock_m = sel;
      end else if (!lh) begin
         lock_m = -1;
      end
      #1;
   endtask

   initial begin
      int exp_rr [6];
      exp_rr = '{0, 1, 2, 0, 1, 2};
      idle_inputs();
      bus.s_rdata_i = 32'hA5A5_A5A5;
      bus1.m_req_i = '0; bus1.m_addr_i = '0; bus1.m_we_i = '0; bus1.m_be_i = '0;
      bus1.m_wdata_i = '0; bus1.s_gnt_i = 1'b0; bus1.s_rvalid_i = 1'b0; bus1.s_rdata_i = '0;

      // reset: rdata passthrough and quiet outputs while held
      @(negedge clk);
      check("rst_rdata", bus.m_rdata_o, 32'hA5A5_A5A5);
      check("rst_s_req", bus.s_req_o, 1'b0);
      check("rst_gnt", bus.m_gnt_o, 3'b000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();

      // idle after reset
      for (int c = 0; c < 2; c++) step();
      check("idle_s_req", last_sreq, 1'b0);
      check("idle_rvalid", last_rv, 3'b000);
      check("idle_err", last_err, 1'b0);

      // all three request, grant always, response the cycle after each accept
      gnt_log.delete();
      for (int c = 0; c < 7; c++) begin
         for (int i = 0; i < N; i++)
            set_m(i, c < 6, 32'h1000 * (i + 1) + c, c[0], 4'hF, 32'hB000 + i);
         bus.s_gnt_i = 1'b1;
         bus.s_rvalid_i = (q.size() > 0);
         bus.s_rdata_i = 32'hD000 + ((q.size() > 0) ? q[0] : 0);
         step();
      end
      check("rr_count", gnt_log.size(), 6);
      for (int k = 0; k < 6; k++)
         check("rr_order", (k < gnt_log.size()) ? gnt_log[k] : 99, exp_rr[k]);

      // stall on master 1 with master 0 joining: address stays bound to master 1
      idle_inputs();
      for (int c = 0; c < 5; c++) begin
         set_m(1, c < 4, 32'h0000_1110, 1'b1, 4'h3, 32'h1111);
         set_m(0, c >= 1, 32'h0000_0AA0, 1'b0, 4'hF, 32'h0);
         bus.s_gnt_i = (c >= 3);
         step();
         if (c < 4) check("stall_addr", last_addr, 32'h0000_1110);
         if (c == 3) check("stall_gnt_m1", last_gnt, 3'b010);
         if (c == 4) check("stall_gnt_m0", last_gnt, 3'b001);
      end
      idle_inputs();
      bus.s_rvalid_i = 1'b1;
      step();
      check("stall_rsp_m1", last_rv, 3'b010);
      step();
      check("stall_rsp_m0", last_rv, 3'b001);

      // fill the FIFO with masters 2 and 0, then free one slot
      idle_inputs();
      set_m(2, 1'b1, 32'h2220, 1'b0, 4'hF, 32'h0);
      set_m(0, 1'b1, 32'h0220, 1'b0, 4'hF, 32'h0);
      bus.s_gnt_i = 1'b1;
      step(); check("full_acc1", last_sreq, 1'b1);
      step(); check("full_acc2", last_sreq, 1'b1);
      step(); check("full_block", last_sreq, 1'b0);
      bus.s_rvalid_i = 1'b1;
      step();
      check("full_pop_sreq", last_sreq, 1'b0);
      check("full_pop_rv", last_rv, 3'b100);
      bus.s_rvalid_i = 1'b0;
      step(); check("full_resume", last_sreq, 1'b1);
      idle_inputs();
      bus.s_rvalid_i = 1'b1;
      step(); step();

      // response with nothing outstanding
      idle_inputs();
      bus.s_rvalid_i = 1'b1;
      step();
      check("err_pulse", last_err, 1'b1);
      check("err_rvalid", last_rv, 3'b000);
      bus.s_rvalid_i = 1'b0;
      step();
      check("err_clear", last_err, 1'b0);

      // reset with transactions outstanding, then a late response
      set_m(0, 1'b1, 32'h0330, 1'b0, 4'hF, 32'h0);
      bus.s_gnt_i = 1'b1;
      step(); step();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.s_rvalid_i = 1'b1;
      step();
      check("rst_late_err", last_err, 1'b1);
      check("rst_late_rv", last_rv, 3'b000);

      // randomized traffic; stalled masters usually keep their request stable
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(lock_m == i && bus.m_req_i[i] && ($urandom_range(9) != 0)))
               set_m(i, $urandom_range(9) < 6, $urandom, $urandom_range(1),
                     4'($urandom_range(15)), $urandom);
         end
         bus.s_gnt_i = $urandom_range(1);
         bus.s_rvalid_i = ($urandom_range(2) == 0);
         bus.s_rdata_i = $urandom;
         step();
      end
      idle_inputs();

      // single-master build: read then write pass straight through on bit 0
      bus1.m_req_i = 1'b1; bus1.m_addr_i = 32'h40; bus1.m_we_i = 1'b0; bus1.m_be_i = 4'hF;
      bus1.s_gnt_i = 1'b1;
      @(negedge clk);
      check("n1_rd_gnt", bus1.m_gnt_o, 1'b1);
      check("n1_rd_addr", bus1.s_addr_o, 32'h40);
      check("n1_rd_we", bus1.s_we_o, 1'b0);
      @(posedge clk); #1;
      bus1.m_addr_i = 32'h44; bus1.m_we_i = 1'b1; bus1.m_wdata_i = 32'hCAFE;
      bus1.s_rvalid_i = 1'b1; bus1.s_rdata_i = 32'h1234;
      @(negedge clk);
      check("n1_wr_gnt", bus1.m_gnt_o, 1'b1);
      check("n1_wr_we", bus1.s_we_o, 1'b1);
      check("n1_wr_wdata", bus1.s_wdata_o, 32'hCAFE);
      check("n1_rd_rvalid", bus1.m_rvalid_o, 1'b1);
      check("n1_rd_rdata", bus1.m_rdata_o, 32'h1234);
      @(posedge clk); #1;
      bus1.m_req_i = 1'b0; bus1.s_gnt_i = 1'b0;
      @(negedge clk);
      check("n1_wr_rvalid", bus1.m_rvalid_o, 1'b1);
      check("n1_wr_err", bus1.rsp_err_o, 1'b0);
      check("n1_idle_sreq", bus1.s_req_o, 1'b0);
      @(posedge clk); #1;
      bus1.s_rvalid_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
